// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared definitions for the mm:ss BCD countdown timer:
//                FSM state encoding, BCD digit width, default digit limits
//                and the preset clamp helper used by every digit.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package timer_pkg;

   localparam int c_digit_w    = 4;   // one BCD digit
   localparam int c_ones_limit = 9;   // ones digits count 9..0
   localparam int c_tens_limit = 5;   // tens digits count 5..0

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Out-of-range presets saturate to the digit's limit rather than
   // loading a non-BCD or non-time value.
   function automatic logic [c_digit_w-1:0] clamp_digit(
      input logic [c_digit_w-1:0] value,
      input logic [c_digit_w-1:0] limit
   );
      return (value > limit) ? limit : value;
   endfunction

endpackage
`default_nettype wire

// File: rtl/down_counter_digit.sv
`default_nettype none
// ============================================================================
//  Module      : down_counter_digit
//  Description : One decrementing BCD digit with borrow chaining. Decrements
//                when en and borrow_in are both high; at 0 it wraps to limit
//                and raises borrow_out so the next digit up decrements too.
//  Ports       : clk        - system clock
//                reset      - asynchronous active-low reset (value -> 0)
//                borrow_in  - decrement request from the digit below
//                en         - global count enable
//                load       - load clamped load_value (has priority)
//                load_value - preset value
//                limit      - max / wrap value of this digit
//                value      - current digit
//                borrow_out - combinational borrow to the next digit
//  Revision    : 1.0  initial release
// ============================================================================
module down_counter_digit
   import timer_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 borrow_in,
   input  logic                 en,
   input  logic                 load,
   input  logic [c_digit_w-1:0] load_value,
   input  logic [c_digit_w-1:0] limit,
   output logic [c_digit_w-1:0] value,
   output logic                 borrow_out
);

   logic [c_digit_w-1:0] r_value;
   logic                 w_dec;

   assign w_dec      = en & borrow_in;
   assign borrow_out = w_dec & (r_value == '0);
   assign value      = r_value;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_value <= '0;
      end else if (load) begin
         r_value <= clamp_digit(load_value, limit);
      end else if (w_dec) begin
         r_value <= (r_value == '0) ? limit : r_value - 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Four-digit BCD mm:ss countdown timer. FSM IDLE/RUN/PAUSE/DONE
//                with load/start_pause arbitration and a borrow chain
//                sec_o -> sec_t -> min_o -> min_t.
//  Ports       : clk, reset (async, active-low)
//                tick        - 1 Hz one-clk enable pulse
//                start_pause - start / pause / resume / acknowledge pulse
//                load        - load set_* presets (ignored in RUN)
//                set_*       - preset digits
//                min_t/min_o/sec_t/sec_o - current digits
//                running / done - decoded state
//  Revision    : 1.0  initial release
// ============================================================================
module countdown_timer
   import timer_pkg::*;
#(
   parameter int SEC_TENS_LIMIT = c_tens_limit,
   parameter int MIN_TENS_LIMIT = c_tens_limit,
   parameter int ONES_LIMIT     = c_ones_limit
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 start_pause,
   input  logic                 load,
   input  logic [c_digit_w-1:0] set_min_t,
   input  logic [c_digit_w-1:0] set_min_o,
   input  logic [c_digit_w-1:0] set_sec_t,
   input  logic [c_digit_w-1:0] set_sec_o,
   output logic [c_digit_w-1:0] min_t,
   output logic [c_digit_w-1:0] min_o,
   output logic [c_digit_w-1:0] sec_t,
   output logic [c_digit_w-1:0] sec_o,
   output logic                 running,
   output logic                 done
);

   localparam logic [c_digit_w-1:0] c_sec_t_lim = c_digit_w'(SEC_TENS_LIMIT);
   localparam logic [c_digit_w-1:0] c_min_t_lim = c_digit_w'(MIN_TENS_LIMIT);
   localparam logic [c_digit_w-1:0] c_ones_lim  = c_digit_w'(ONES_LIMIT);

   state_t r_state;

   logic w_run;
   logic w_load_acc;
   logic w_tick_acc;
   logic w_is_zero;
   logic w_is_one;
   logic w_b_sec_t;
   logic w_b_min_o;
   logic w_b_min_t;
   logic w_unused_min_t_borrow;

   assign w_run     = (r_state == ST_RUN);
   assign w_is_zero = ({min_t, min_o, sec_t, sec_o} == 16'h0000);
   assign w_is_one  = ({min_t, min_o, sec_t, sec_o} == 16'h0001);

   // Load is only honoured outside RUN; it also shadows start_pause.
   assign w_load_acc = load & ~w_run;
   // A pause request drops a coincident tick; 00:00 never decrements.
   assign w_tick_acc = w_run & tick & ~start_pause & ~w_is_zero;

   assign running = (r_state == ST_RUN);
   assign done    = (r_state == ST_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!load && start_pause && !w_is_zero) r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (start_pause)               r_state <= ST_PAUSE;
               else if (w_tick_acc && w_is_one) r_state <= ST_DONE;
            end
            ST_PAUSE: begin
               if (load)             r_state <= ST_IDLE;
               else if (start_pause) r_state <= ST_RUN;
            end
            ST_DONE: begin
               if (load || start_pause) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   down_counter_digit u_sec_o (
      .clk        (clk),
      .reset      (reset),
      .borrow_in  (w_tick_acc),
      .en         (w_run),
      .load       (w_load_acc),
      .load_value (set_sec_o),
      .limit      (c_ones_lim),
      .value      (sec_o),
      .borrow_out (w_b_sec_t)
   );

   down_counter_digit u_sec_t (
      .clk        (clk),
      .reset      (reset),
      .borrow_in  (w_b_sec_t),
      .en         (w_run),
      .load       (w_load_acc),
      .load_value (set_sec_t),
      .limit      (c_sec_t_lim),
      .value      (sec_t),
      .borrow_out (w_b_min_o)
   );

   down_counter_digit u_min_o (
      .clk        (clk),
      .reset      (reset),
      .borrow_in  (w_b_min_o),
      .en         (w_run),
      .load       (w_load_acc),
      .load_value (set_min_o),
      .limit      (c_ones_lim),
      .value      (min_o),
      .borrow_out (w_b_min_t)
   );

   // The top digit's borrow can never fire because 00:00 is never decremented.
   down_counter_digit u_min_t (
      .clk        (clk),
      .reset      (reset),
      .borrow_in  (w_b_min_t),
      .en         (w_run),
      .load       (w_load_acc),
      .load_value (set_min_t),
      .limit      (c_min_t_lim),
      .value      (min_t),
      .borrow_out (w_unused_min_t_borrow)
   );

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Directed self-checking bench for countdown_timer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_countdown_timer;

   logic       clk;
   logic       reset;
   logic       tick;
   logic       start_pause;
   logic       load;
   logic [3:0] set_min_t, set_min_o, set_sec_t, set_sec_o;
   logic [3:0] min_t, min_o, sec_t, sec_o;
   logic       running, done;

   int n_total = 0;
   int n_bad   = 0;

   countdown_timer #(
      .SEC_TENS_LIMIT (5),
      .MIN_TENS_LIMIT (5),
      .ONES_LIMIT     (9)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .start_pause (start_pause),
      .load        (load),
      .set_min_t   (set_min_t),
      .set_min_o   (set_min_o),
      .set_sec_t   (set_sec_t),
      .set_sec_o   (set_sec_o),
      .min_t       (min_t),
      .min_o       (min_o),
      .sec_t       (sec_t),
      .sec_o       (sec_o),
      .running     (running),
      .done        (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock cycle with the given controls asserted; returns #1 after the edge.
   task automatic cyc(input logic sp, input logic ld, input logic tk);
      @(negedge clk);
      start_pause = sp;
      load        = ld;
      tick        = tk;
      @(posedge clk);
      #1;
      start_pause = 1'b0;
      load        = 1'b0;
      tick        = 1'b0;
   endtask

   task automatic preset(input logic [3:0] mt, input logic [3:0] mo,
                         input logic [3:0] st, input logic [3:0] so);
      set_min_t = mt;
      set_min_o = mo;
      set_sec_t = st;
      set_sec_o = so;
   endtask

   function automatic logic [15:0] cnt();
      return {min_t, min_o, sec_t, sec_o};
   endfunction

   initial begin
      reset       = 1'b0;
      tick        = 1'b0;
      start_pause = 1'b0;
      load        = 1'b0;
      preset(4'd0, 4'd0, 4'd0, 4'd0);
      #12;
      chk("reset_count",   32'(cnt()),  32'h0000);
      chk("reset_running", 32'(running), 32'd0);
      chk("reset_done",    32'(done),    32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Clamp on load: 0 12 7 3 -> 09:53
      preset(4'd0, 4'd12, 4'd7, 4'd3);
      cyc(1'b0, 1'b1, 1'b0);
      chk("clamp_load", 32'(cnt()), 32'h0953);

      // Tick in IDLE is lost
      cyc(1'b0, 1'b0, 1'b1);
      chk("idle_tick", 32'(cnt()), 32'h0953);

      // start_pause at 00:00 in IDLE stays IDLE
      preset(4'd0, 4'd0, 4'd0, 4'd0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("zero_start_run", 32'(running), 32'd0);
      chk("zero_start_cnt", 32'(cnt()),   32'h0000);

      // Load 01:00, start, tick -> 00:59
      preset(4'd0, 4'd1, 4'd0, 4'd0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("start_running", 32'(running), 32'd1);
      cyc(1'b0, 1'b0, 1'b1);
      chk("first_tick", 32'(cnt()), 32'h0059);

      // Load during RUN ignored
      preset(4'd3, 4'd3, 4'd3, 4'd3);
      cyc(1'b0, 1'b1, 1'b0);
      chk("run_load_cnt", 32'(cnt()),   32'h0059);
      chk("run_load_run", 32'(running), 32'd1);

      // Pause, then load in PAUSE -> IDLE with 10:00
      cyc(1'b1, 1'b0, 1'b0);
      chk("pause_run", 32'(running), 32'd0);
      preset(4'd1, 4'd0, 4'd0, 4'd0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("pause_load_cnt", 32'(cnt()), 32'h1000);
      cyc(1'b0, 1'b0, 1'b1);
      chk("pause_load_idle", 32'(cnt()), 32'h1000);

      // Full borrow chain: 10:00 -> 09:59
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("wrap_minutes", 32'(cnt()), 32'h0959);

      // Terminal count: 00:02 -> 00:01 -> 00:00, DONE
      cyc(1'b1, 1'b0, 1'b0);
      preset(4'd0, 4'd0, 4'd0, 4'd2);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("term_t1", 32'(cnt()), 32'h0001);
      chk("term_t1_done", 32'(done), 32'd0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("term_t2", 32'(cnt()), 32'h0000);
      chk("term_done", 32'(done), 32'd1);
      chk("term_run",  32'(running), 32'd0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("term_hold", 32'(cnt()), 32'h0000);
      cyc(1'b1, 1'b0, 1'b0);
      chk("ack_done", 32'(done), 32'd0);
      chk("ack_run",  32'(running), 32'd0);
      chk("ack_cnt",  32'(cnt()), 32'h0000);

      // Pause priority at 00:10
      preset(4'd0, 4'd0, 4'd1, 4'd0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      chk("pp_run", 32'(running), 32'd0);
      chk("pp_cnt", 32'(cnt()), 32'h0010);
      cyc(1'b0, 1'b0, 1'b1);
      chk("pp_pause_tick", 32'(cnt()), 32'h0010);
      cyc(1'b1, 1'b0, 1'b1);
      chk("pp_resume_run", 32'(running), 32'd1);
      chk("pp_resume_cnt", 32'(cnt()), 32'h0010);
      cyc(1'b0, 1'b0, 1'b1);
      chk("pp_next_tick", 32'(cnt()), 32'h0009);

      // load + start_pause together in PAUSE: load wins, ends in IDLE
      cyc(1'b1, 1'b0, 1'b0);
      preset(4'd0, 4'd0, 4'd0, 4'd5);
      cyc(1'b1, 1'b1, 1'b0);
      chk("ld_sp_cnt", 32'(cnt()), 32'h0005);
      chk("ld_sp_run", 32'(running), 32'd0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("ld_sp_idle", 32'(cnt()), 32'h0005);

      // Asynchronous reset mid-RUN at 05:30
      preset(4'd0, 4'd5, 4'd3, 4'd0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("pre_reset_run", 32'(running), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      chk("async_cnt",  32'(cnt()),  32'h0000);
      chk("async_run",  32'(running), 32'd0);
      chk("async_done", 32'(done),    32'd0);
      @(negedge clk);
      reset = 1'b1;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
